// File: rtl/receptor_adc_spi_pkg.sv
// Shared frame constants and FSM state encoding for the SPI ADC receiver,
// also reused by the downstream padding stage and the benches.
package receptor_adc_spi_pkg;

    localparam int ADC_W   = 12;
    localparam int N_CEROS = 4;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        CONV   = 2'd1,
        ESPERA = 2'd2
    } estado_t;

endpackage

// File: rtl/receptor_adc_spi_divisor_sclk.sv
// SCLK generator: counts 0..DIV-1 while enabled and toggles sclk at terminal
// count; flags which direction the coming toggle goes. Idles high when disabled.
module divisor_sclk #(
    parameter int DIV = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic sclk,
    output logic tick_bajada,
    output logic tick_subida
);

    localparam logic [7:0] DIV_FIN = 8'(DIV - 1);

    logic [7:0] cnt_reg;
    logic       sclk_reg;
    logic       fin;

    assign fin         = en && (cnt_reg == DIV_FIN);
    assign tick_bajada = fin && sclk_reg;
    assign tick_subida = fin && !sclk_reg;
    assign sclk        = sclk_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg  <= '0;
            sclk_reg <= 1'b1;
        end else if (!en) begin
            cnt_reg  <= '0;
            sclk_reg <= 1'b1;
        end else if (fin) begin
            cnt_reg  <= '0;
            sclk_reg <= !sclk_reg;
        end else begin
            cnt_reg  <= cnt_reg + 8'd1;
        end
    end

endmodule

// File: rtl/receptor_adc_spi.sv
// Serial capture front end for a 12-bit SPI ADC: one CS/SCLK frame per request.
// Optional macro RECEPTOR_ADC_VERIF_EN adds error_trama (non-zero leading bits).
module receptor_adc_spi
    import receptor_adc_spi_pkg::*;
#(
    parameter int DIV     = 5,
    parameter int N_FRAME = 16,
    parameter int QUIET   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inicio,
    input  logic             sdata,
    output logic             cs_n,
    output logic             sclk,
    output logic [ADC_W-1:0] datoADC,
    output logic             dato_listo,
    output logic             ocupado
`ifdef RECEPTOR_ADC_VERIF_EN
    ,
    output logic             error_trama
`endif
);

    localparam int BW = $clog2(N_FRAME + 1);
    localparam int QW = (QUIET > 1) ? $clog2(QUIET) : 1;
    localparam logic [BW-1:0] B_FIN = BW'(N_FRAME);
    localparam logic [QW-1:0] Q_FIN = QW'(QUIET - 1);

    estado_t            estado_reg, estado_next;
    logic [BW-1:0]      bit_cnt_reg;
    logic [QW-1:0]      quiet_cnt_reg;
    logic [N_FRAME-1:0] shifter_reg;
    logic [N_FRAME-1:0] shift_next;
    logic               cs_n_reg;
    logic [ADC_W-1:0]   dato_reg;
    logic               listo_reg;
    logic               tick_bajada, tick_subida;
    logic               fin_trama;
    logic               arranque;

    divisor_sclk #(.DIV(DIV)) u_divisor (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (estado_reg == CONV),
        .sclk        (sclk),
        .tick_bajada (tick_bajada),
        .tick_subida (tick_subida)
    );

    // bit_cnt counts bits launched by the ADC (falling edges); the frame ends
    // on the rising edge that samples the last of them.
    assign shift_next = {shifter_reg[N_FRAME-2:0], sdata};
    assign fin_trama  = tick_subida && (bit_cnt_reg == B_FIN);
    assign arranque   = (estado_reg == REPOSO) && inicio;

    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            REPOSO:  if (inicio)                 estado_next = CONV;
            CONV:    if (fin_trama)              estado_next = ESPERA;
            ESPERA:  if (quiet_cnt_reg == Q_FIN) estado_next = REPOSO;
            default:                             estado_next = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_reg    <= REPOSO;
            bit_cnt_reg   <= '0;
            quiet_cnt_reg <= '0;
            shifter_reg   <= '0;
            cs_n_reg      <= 1'b1;
            dato_reg      <= '0;
            listo_reg     <= 1'b0;
        end else begin
            estado_reg <= estado_next;
            cs_n_reg   <= (estado_next != CONV);
            listo_reg  <= fin_trama;

            if (arranque) begin
                bit_cnt_reg <= '0;
                shifter_reg <= '0;
            end else begin
                if (tick_bajada) bit_cnt_reg <= bit_cnt_reg + 1'b1;
                if (tick_subida) shifter_reg <= shift_next;
            end

            if (estado_reg == ESPERA) quiet_cnt_reg <= quiet_cnt_reg + 1'b1;
            else                      quiet_cnt_reg <= '0;

            if (fin_trama) dato_reg <= shift_next[ADC_W-1:0];
        end
    end

`ifdef RECEPTOR_ADC_VERIF_EN
    logic err_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_reg <= 1'b0;
        else          err_reg <= fin_trama && (|shift_next[N_FRAME-1 -: N_CEROS]);
    end

    assign error_trama = err_reg;
`endif

    assign cs_n       = cs_n_reg;
    assign datoADC    = dato_reg;
    assign dato_listo = listo_reg;
    assign ocupado    = (estado_reg != REPOSO);

endmodule
